// File: rtl/pong_pkg.sv
// Shared types and default constants for the pong game controller and its helpers.
package pong_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_POINT,
        S_OVER
    } state_e;

    localparam int INIT_THRESH = 250000;
    localparam int THRESH_STEP = 10000;
    localparam int MIN_THRESH  = 50000;
    localparam int SERVE_DELAY = 50000000;
    localparam int WIN_SCORE   = 7;

    // Scores stick at 15 rather than wrapping back to zero.
    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s == 4'hf) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/serve_timer.sv
// Serve delay counter: counts 0..DELAY-1 while enabled and flags the last count.
module serve_timer #(
    parameter int DELAY = 50000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic done
);

    localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign done = enable && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (enable && !done) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bounce_ctrl.sv
// Pong game controller: serves the ball, handles wall/paddle bounces, misses and scoring,
// and steers the external x/y trajectory movers through active/direction/threshold.
module bounce_ctrl
    import pong_pkg::*;
#(
    parameter int CWIDTH      = 9,
    parameter int XMAX        = 639,
    parameter int YMAX        = 479,
    parameter int PADDLE_XL   = 8,
    parameter int PADDLE_XR   = 631,
    parameter int PADDLE_H    = 64,
    parameter int INIT_THRESH = pong_pkg::INIT_THRESH,
    parameter int THRESH_STEP = pong_pkg::THRESH_STEP,
    parameter int MIN_THRESH  = pong_pkg::MIN_THRESH,
    parameter int SERVE_DELAY = pong_pkg::SERVE_DELAY,
    parameter int WIN_SCORE   = pong_pkg::WIN_SCORE
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CWIDTH:0]   ball_x,
    input  logic [CWIDTH:0]   ball_y,
    input  logic [CWIDTH:0]   paddle_l_y,
    input  logic [CWIDTH:0]   paddle_r_y,
    output logic              active,
    output logic              x_dir,
    output logic              y_dir,
    output logic [63:0]       threshold,
    output logic [3:0]        score_l,
    output logic [3:0]        score_r,
    output logic              point_l,
    output logic              point_r,
    output logic              game_over
);

    typedef logic [CWIDTH:0]   coord_t;
    typedef logic [CWIDTH+1:0] wide_t;

    localparam coord_t XL_C   = coord_t'(PADDLE_XL);
    localparam coord_t XR_C   = coord_t'(PADDLE_XR);
    localparam coord_t XMAX_C = coord_t'(XMAX);
    localparam coord_t YMAX_C = coord_t'(YMAX);
    localparam wide_t  H_C    = wide_t'(PADDLE_H);

    state_e      state_q, state_d;
    coord_t      bx_q, by_q;
    logic        x_dir_q, x_dir_d, y_dir_q, y_dir_d;
    logic [63:0] thr_q, thr_d;
    logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;
    logic        point_l_q, point_l_d, point_r_q, point_r_d;
    logic        active_q, active_d, game_over_q, game_over_d;
    logic        timer_load, timer_done;
    logic        strobe, hit_l, hit_r, miss_l, miss_r;

    // Paddle span check one bit wider so paddle top + height cannot overflow.
    function automatic logic on_paddle(input coord_t y, input coord_t top);
        wide_t y_w, top_w;
        y_w   = {1'b0, y};
        top_w = {1'b0, top};
        return (y_w >= top_w) && (y_w < top_w + H_C);
    endfunction

    function automatic logic [63:0] speed_up(input logic [63:0] thr);
        if (thr >= 64'(MIN_THRESH) + 64'(THRESH_STEP)) begin
            return thr - 64'(THRESH_STEP);
        end
        return 64'(MIN_THRESH);
    endfunction

    assign strobe = (ball_x != bx_q) || (ball_y != by_q);
    assign hit_l  = !x_dir_q && (ball_x == XL_C) && on_paddle(ball_y, paddle_l_y);
    assign hit_r  =  x_dir_q && (ball_x == XR_C) && on_paddle(ball_y, paddle_r_y);
    assign miss_r = !x_dir_q && (ball_x == '0);
    assign miss_l =  x_dir_q && (ball_x >= XMAX_C);

    serve_timer #(.DELAY(SERVE_DELAY)) u_serve_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (timer_load),
        .enable  (state_q == S_SERVE),
        .done    (timer_done)
    );

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        x_dir_d    = x_dir_q;
        y_dir_d    = y_dir_q;
        thr_d      = thr_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        point_l_d  = 1'b0;
        point_r_d  = 1'b0;
        timer_load = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d   = S_SERVE;
                    score_l_d = '0;
                    score_r_d = '0;
                end
            end
            S_SERVE: begin
                if (timer_done) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (strobe) begin
                    if (ball_y == '0)         y_dir_d = 1'b1;
                    else if (ball_y >= YMAX_C) y_dir_d = 1'b0;
                    if (hit_l) begin
                        x_dir_d = 1'b1;
                        thr_d   = speed_up(thr_q);
                    end else if (hit_r) begin
                        x_dir_d = 1'b0;
                        thr_d   = speed_up(thr_q);
                    end
                    // A miss discards any bounce computed in the same cycle.
                    if (miss_r || miss_l) begin
                        x_dir_d = x_dir_q;
                        y_dir_d = y_dir_q;
                        thr_d   = thr_q;
                        state_d = S_POINT;
                    end
                    if (miss_r) begin
                        score_r_d = score_inc(score_r_q);
                        point_r_d = 1'b1;
                    end else if (miss_l) begin
                        score_l_d = score_inc(score_l_q);
                        point_l_d = 1'b1;
                    end
                end
            end
            S_POINT: begin
                if (score_l_q == 4'(WIN_SCORE) || score_r_q == 4'(WIN_SCORE)) state_d = S_OVER;
                else                                                          state_d = S_SERVE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_SERVE && state_q != S_SERVE) begin
            timer_load = 1'b1;
            thr_d      = 64'(INIT_THRESH);
            x_dir_d    = 1'b1;
            y_dir_d    = ~y_dir_q;
        end

        active_d    = (state_d == S_PLAY);
        game_over_d = (state_d == S_OVER);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            bx_q        <= '0;
            by_q        <= '0;
            x_dir_q     <= 1'b1;
            y_dir_q     <= 1'b0;
            thr_q       <= 64'(INIT_THRESH);
            score_l_q   <= '0;
            score_r_q   <= '0;
            point_l_q   <= 1'b0;
            point_r_q   <= 1'b0;
            active_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bx_q        <= ball_x;
            by_q        <= ball_y;
            x_dir_q     <= x_dir_d;
            y_dir_q     <= y_dir_d;
            thr_q       <= thr_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            point_l_q   <= point_l_d;
            point_r_q   <= point_r_d;
            active_q    <= active_d;
            game_over_q <= game_over_d;
        end
    end

    assign active    = active_q;
    assign x_dir     = x_dir_q;
    assign y_dir     = y_dir_q;
    assign threshold = thr_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign point_l   = point_l_q;
    assign point_r   = point_r_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_bounce_ctrl.sv
// Directed bench for bounce_ctrl with small-field parameters and hand-computed expectations.
module tb_bounce_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  ball_x, ball_y, paddle_l_y, paddle_r_y;
    logic        active, x_dir, y_dir, point_l, point_r, game_over;
    logic [63:0] threshold;
    logic [3:0]  score_l, score_r;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    bounce_ctrl #(
        .CWIDTH(3), .XMAX(15), .YMAX(11), .PADDLE_XL(1), .PADDLE_XR(14), .PADDLE_H(4),
        .INIT_THRESH(100), .THRESH_STEP(30), .MIN_THRESH(40), .SERVE_DELAY(3), .WIN_SCORE(2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .active     (active),
        .x_dir      (x_dir),
        .y_dir      (y_dir),
        .threshold  (threshold),
        .score_l    (score_l),
        .score_r    (score_r),
        .point_l    (point_l),
        .point_r    (point_r),
        .game_over  (game_over)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic move(input logic [3:0] x, input logic [3:0] y);
        ball_x = x;
        ball_y = y;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0;
        ball_x = 4'd8; ball_y = 4'd5; paddle_l_y = 4'd0; paddle_r_y = 4'd0;
        #12;
        check("rst_active", active, 1'b0);
        check("rst_x_dir", x_dir, 1'b1);
        check("rst_y_dir", y_dir, 1'b0);
        check("rst_thr", threshold, 64'd100);
        check("rst_scores", {score_l, score_r}, 8'd0);
        check("rst_pulses", {point_l, point_r, game_over}, 3'b000);
        reset_n = 1'b1;
        tick(); tick();
        check("idle_active", active, 1'b0);

        // Serve: three counting cycles with active low, then play.
        pulse_start();
        check("serve_c0_active", active, 1'b0);
        check("serve_y_toggle", y_dir, 1'b1);
        check("serve_x_dir", x_dir, 1'b1);
        tick();
        check("serve_c1_active", active, 1'b0);
        tick();
        check("serve_c2_active", active, 1'b0);
        tick();
        check("play_active", active, 1'b1);
        check("play_thr", threshold, 64'd100);

        // Right paddle hit plus bottom wall in the same cycle.
        paddle_r_y = 4'd9;
        move(4'd14, 4'd11);
        check("wallpad_x_dir", x_dir, 1'b0);
        check("wallpad_y_dir", y_dir, 1'b0);
        check("wallpad_thr", threshold, 64'd70);

        // Left paddle hit, ball steps 2 -> 1.
        paddle_l_y = 4'd4;
        move(4'd2, 4'd5);
        check("approach_x_dir", x_dir, 1'b0);
        move(4'd1, 4'd5);
        check("lhit_x_dir", x_dir, 1'b1);
        check("lhit_thr", threshold, 64'd40);

        // Another hit at the floor: threshold stays saturated.
        paddle_r_y = 4'd4;
        move(4'd14, 4'd5);
        check("rhit_x_dir", x_dir, 1'b0);
        check("sat_thr", threshold, 64'd40);

        // Ball at the left face but off the paddle, then paddle slides under a still ball.
        paddle_l_y = 4'd0;
        move(4'd1, 4'd9);
        check("lmiss_pad_x_dir", x_dir, 1'b0);
        paddle_l_y = 4'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("no_strobe_x_dir", x_dir, 1'b0);
        check("start_ign_play", active, 1'b1);

        move(4'd2, 4'd0);
        check("top_wall_y_dir", y_dir, 1'b1);

        // First miss on the left side scores for the right player.
        move(4'd0, 4'd4);
        check("miss1_point_r", point_r, 1'b1);
        check("miss1_point_l", point_l, 1'b0);
        check("miss1_score_r", score_r, 4'd1);
        check("miss1_active", active, 1'b0);
        tick();
        check("miss1_pulse_end", point_r, 1'b0);
        check("serve2_game_over", game_over, 1'b0);
        check("serve2_y_toggle", y_dir, 1'b0);
        check("serve2_thr", threshold, 64'd100);
        tick(); tick();
        check("serve2_wait", active, 1'b0);
        tick();
        check("serve2_play", active, 1'b1);

        move(4'd14, 4'd4);
        check("serve2_rhit_thr", threshold, 64'd70);
        // Miss coinciding with the top wall: the wall bounce is discarded.
        move(4'd0, 4'd0);
        check("miss2_score_r", score_r, 4'd2);
        check("miss2_point_r", point_r, 1'b1);
        check("miss2_wall_ignored", y_dir, 1'b0);
        tick();
        check("over_game_over", game_over, 1'b1);
        check("over_active", active, 1'b0);
        check("over_pulse_end", point_r, 1'b0);
        tick();
        check("over_hold_score", score_r, 4'd2);

        // Restart from OVER.
        pulse_start();
        check("restart_scores", {score_l, score_r}, 8'd0);
        check("restart_game_over", game_over, 1'b0);
        check("restart_y_toggle", y_dir, 1'b1);
        tick(); tick(); tick();
        check("restart_play", active, 1'b1);

        // Right-side miss scores for the left player.
        move(4'd15, 4'd6);
        check("missl_score_l", score_l, 4'd1);
        check("missl_point_l", point_l, 1'b1);
        check("missl_point_r", point_r, 1'b0);
        tick();
        check("missl_not_over", game_over, 1'b0);
        tick(); tick(); tick();
        check("serve3_play", active, 1'b1);

        // Asynchronous reset between edges.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_active", active, 1'b0);
        check("async_rst_score_l", score_l, 4'd0);
        check("async_rst_thr", threshold, 64'd100);
        pulse_start();
        check("start_in_reset", active, 1'b0);
        #2;
        reset_n = 1'b1;
        tick(); tick(); tick(); tick();
        check("idle_after_reset", active, 1'b0);
        pulse_start();
        tick(); tick(); tick();
        check("post_reset_play", active, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
